// File: rtl/sgpr_rf_pkg.sv
// sgpr_rf_pkg: shared types and helpers for the banked SGPR register file.
//   sgpr_word_t  - one 32-bit scalar register word
//   mask_legal   - write-mask legality (contiguous from bit 0, power-of-two
//                  count, start address aligned to that count; 0 is a no-op)
//   split_addr   - word address -> {row, bank}
//   resolve_we   - per-bank write priority (port 0 > port 1 > port 2)
package sgpr_rf_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NUM_RD   = 3;
    localparam int unsigned NUM_WR   = 3;
    localparam int unsigned MASK_MAX = 32;

    typedef logic [WORD_W-1:0] sgpr_word_t;

    typedef struct packed {
        logic [31:0] row;
        logic [31:0] bank;
    } addr_split_t;

    // A zero mask is legal and writes nothing.
    function automatic logic mask_legal(input logic [MASK_MAX-1:0] mask,
                                        input logic [31:0]         addr);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < int'(MASK_MAX); i++) begin
            n = n + 32'(mask[i]);
        end
        if (mask == '0) begin
            return 1'b1;
        end
        return ((mask & (mask + MASK_MAX'(1))) == '0) &&
               ((n & (n - 32'(1))) == '0) &&
               ((addr & (n - 32'(1))) == '0);
    endfunction

    function automatic addr_split_t split_addr(input logic [31:0]  addr,
                                               input int unsigned  bank_bits);
        addr_split_t s;
        s.bank = addr & ((32'(1) << bank_bits) - 32'(1));
        s.row  = addr >> bank_bits;
        return s;
    endfunction

    // Drop lower-priority enables that hit a row already claimed this cycle.
    function automatic logic [2:0] resolve_we(input logic [2:0]  we,
                                              input logic [31:0] row0,
                                              input logic [31:0] row1,
                                              input logic [31:0] row2);
        logic [2:0] win;
        win = we;
        if (we[0] && we[1] && (row0 == row1)) begin
            win[1] = 1'b0;
        end
        if (we[2] && ((we[0] && (row0 == row2)) || (we[1] && (row1 == row2)))) begin
            win[2] = 1'b0;
        end
        return win;
    endfunction

endpackage

// File: rtl/sgpr_banked_rf_if.sv
// sgpr_banked_rf_if: read/write port bundle of the banked SGPR file.
//   rdN_en/rdN_addr  -> request; rdN_data/rdN_valid <- registered result
//   wrN_en (mask)/wrN_addr/wrN_data -> write; wr_err <- sticky illegal-mask flags
//   master: arbiter side; slave: register-file side.
interface sgpr_banked_rf_if
    import sgpr_rf_pkg::*;
#(
    parameter int unsigned AW        = 9,
    parameter int unsigned RD0_WORDS = 4,
    parameter int unsigned RD1_WORDS = 2,
    parameter int unsigned RD2_WORDS = 2,
    parameter int unsigned WR0_WORDS = 4,
    parameter int unsigned WR1_WORDS = 2,
    parameter int unsigned WR2_WORDS = 2
) ();

    logic                          rd0_en;
    logic [AW-1:0]                 rd0_addr;
    logic [WORD_W*RD0_WORDS-1:0]   rd0_data;
    logic                          rd0_valid;
    logic                          rd1_en;
    logic [AW-1:0]                 rd1_addr;
    logic [WORD_W*RD1_WORDS-1:0]   rd1_data;
    logic                          rd1_valid;
    logic                          rd2_en;
    logic [AW-1:0]                 rd2_addr;
    logic [WORD_W*RD2_WORDS-1:0]   rd2_data;
    logic                          rd2_valid;
    logic [WR0_WORDS-1:0]          wr0_en;
    logic [AW-1:0]                 wr0_addr;
    logic [WORD_W*WR0_WORDS-1:0]   wr0_data;
    logic [WR1_WORDS-1:0]          wr1_en;
    logic [AW-1:0]                 wr1_addr;
    logic [WORD_W*WR1_WORDS-1:0]   wr1_data;
    logic [WR2_WORDS-1:0]          wr2_en;
    logic [AW-1:0]                 wr2_addr;
    logic [WORD_W*WR2_WORDS-1:0]   wr2_data;
    logic [2:0]                    wr_err;

    modport master (
        output rd0_en, rd0_addr, rd1_en, rd1_addr, rd2_en, rd2_addr,
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        output wr2_en, wr2_addr, wr2_data,
        input  rd0_data, rd0_valid, rd1_data, rd1_valid, rd2_data, rd2_valid,
        input  wr_err
    );

    modport slave (
        input  rd0_en, rd0_addr, rd1_en, rd1_addr, rd2_en, rd2_addr,
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        input  wr2_en, wr2_addr, wr2_data,
        output rd0_data, rd0_valid, rd1_data, rd1_valid, rd2_data, rd2_valid,
        output wr_err
    );

endinterface

// File: rtl/sgpr_rf_bank.sv
// sgpr_rf_bank: one bank of ROWS x 32-bit words, 3 combinational read ports,
// 3 write ports with fixed priority (port 0 highest).
//   clk          - write clock
//   we/wrow/wdata - per-port write enable, row, data
//   rrow/rdata   - per-port read row and combinational read data
// Optional macro SGPR_RF_BYPASS_EN: reads see same-cycle winning writes.
module sgpr_rf_bank
    import sgpr_rf_pkg::*;
#(
    parameter int unsigned ROWS = 128,
    parameter int unsigned RW   = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic [NUM_WR-1:0] we,
    input  logic [RW-1:0]     wrow  [NUM_WR],
    input  sgpr_word_t        wdata [NUM_WR],
    input  logic [RW-1:0]     rrow  [NUM_RD],
    output sgpr_word_t        rdata [NUM_RD]
);

`ifdef SGPR_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    sgpr_word_t        mem [ROWS];
    logic [NUM_WR-1:0] we_win;

    assign we_win = resolve_we(we, 32'(wrow[0]), 32'(wrow[1]), 32'(wrow[2]));

    // Winning enables always target distinct rows, so write order is irrelevant.
    always_ff @(posedge clk) begin
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (we_win[p]) begin
                mem[wrow[p]] <= wdata[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < int'(NUM_RD); p++) begin
            rdata[p] = mem[rrow[p]];
            for (int q = 0; q < int'(NUM_WR); q++) begin
                if (BYPASS && we_win[q] && (wrow[q] == rrow[p])) begin
                    rdata[p] = wdata[q];
                end
            end
        end
    end

endmodule

// File: rtl/sgpr_banked_rf.sv
// sgpr_banked_rf: banked 32-bit scalar register file, word a in bank
// a % NUM_BANKS, row a / NUM_BANKS.
//   clk, rst     - clock, asynchronous active-high reset
//   bus (slave)  - 3 read ports (registered data + valid, latency 1),
//                  3 masked write ports, sticky per-port wr_err
// Optional macro SGPR_RF_BYPASS_EN: same-cycle write-to-read forwarding.
module sgpr_banked_rf
    import sgpr_rf_pkg::*;
#(
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned RD0_WORDS = 4,
    parameter int unsigned RD1_WORDS = 2,
    parameter int unsigned RD2_WORDS = 2,
    parameter int unsigned WR0_WORDS = 4,
    parameter int unsigned WR1_WORDS = 2,
    parameter int unsigned WR2_WORDS = 2,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    sgpr_banked_rf_if.slave bus
);

    localparam int unsigned BB     = $clog2(NUM_BANKS);
    localparam int unsigned ROWS   = DEPTH / NUM_BANKS;
    localparam int unsigned RW     = $clog2(ROWS);
    localparam int unsigned LANE_W = NUM_BANKS * WORD_W;

    logic [AW-1:0]        rd_addr  [NUM_RD];
    logic [AW-1:0]        wr_addr  [NUM_WR];
    logic [NUM_BANKS-1:0] wr_mask  [NUM_WR];
    logic [LANE_W-1:0]    wr_lane  [NUM_WR];
    logic [NUM_WR-1:0]    wr_legal;

    logic [NUM_WR-1:0]    bank_we    [NUM_BANKS];
    logic [RW-1:0]        bank_wrow  [NUM_BANKS][NUM_WR];
    sgpr_word_t           bank_wdata [NUM_BANKS][NUM_WR];
    logic [RW-1:0]        bank_rrow  [NUM_BANKS][NUM_RD];
    sgpr_word_t           bank_rdata [NUM_BANKS][NUM_RD];
    sgpr_word_t           rd_word    [NUM_RD][NUM_BANKS];

    logic [WORD_W*RD0_WORDS-1:0] rd0_d, rd0_q;
    logic [WORD_W*RD1_WORDS-1:0] rd1_d, rd1_q;
    logic [WORD_W*RD2_WORDS-1:0] rd2_d, rd2_q;
    logic [NUM_RD-1:0]           rd_valid_q;
    logic [NUM_WR-1:0]           wr_err_q;

    // Normalise ports to full-lane width so every port is steered the same way.
    assign rd_addr[0] = bus.rd0_addr;
    assign rd_addr[1] = bus.rd1_addr;
    assign rd_addr[2] = bus.rd2_addr;
    assign wr_addr[0] = bus.wr0_addr;
    assign wr_addr[1] = bus.wr1_addr;
    assign wr_addr[2] = bus.wr2_addr;
    assign wr_mask[0] = NUM_BANKS'(bus.wr0_en);
    assign wr_mask[1] = NUM_BANKS'(bus.wr1_en);
    assign wr_mask[2] = NUM_BANKS'(bus.wr2_en);
    assign wr_lane[0] = LANE_W'(bus.wr0_data);
    assign wr_lane[1] = LANE_W'(bus.wr1_data);
    assign wr_lane[2] = LANE_W'(bus.wr2_data);

    always_comb begin
        wr_legal = '0;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            wr_legal[p] = mask_legal(MASK_MAX'(wr_mask[p]), 32'(wr_addr[p]));
        end
    end

    // Bank b serves word k = (b - addr % NUM_BANKS) mod NUM_BANKS of each access.
    always_comb begin
        addr_split_t     s;
        logic [BB-1:0]   k;
        logic [AW-1:0]   wa;
        s = '0;
        k = '0;
        wa = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            for (int p = 0; p < int'(NUM_RD); p++) begin
                s  = split_addr(32'(rd_addr[p]), BB);
                k  = BB'(b) - BB'(s.bank);
                wa = rd_addr[p] + AW'(k);
                s  = split_addr(32'(wa), BB);
                bank_rrow[b][p] = RW'(s.row);
            end
            for (int p = 0; p < int'(NUM_WR); p++) begin
                s  = split_addr(32'(wr_addr[p]), BB);
                k  = BB'(b) - BB'(s.bank);
                wa = wr_addr[p] + AW'(k);
                s  = split_addr(32'(wa), BB);
                bank_wrow[b][p]  = RW'(s.row);
                bank_wdata[b][p] = wr_lane[p][WORD_W*k +: WORD_W];
                // Writes sampled together with reset are dropped.
                bank_we[b][p]    = !rst && wr_legal[p] && wr_mask[p][k];
            end
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < int'(NUM_BANKS); gb++) begin : g_bank
            sgpr_rf_bank #(
                .ROWS (ROWS),
                .RW   (RW)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[gb]),
                .wrow  (bank_wrow[gb]),
                .wdata (bank_wdata[gb]),
                .rrow  (bank_rrow[gb]),
                .rdata (bank_rdata[gb])
            );
        end
    endgenerate

    // Rotate bank outputs back into access order.
    always_comb begin
        addr_split_t   s;
        logic [BB-1:0] bk;
        s = '0;
        bk = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            s = split_addr(32'(rd_addr[p]), BB);
            for (int k = 0; k < int'(NUM_BANKS); k++) begin
                bk = BB'(s.bank) + BB'(k);
                rd_word[p][k] = bank_rdata[bk][p];
            end
        end
    end

    always_comb begin
        rd0_d = '0;
        rd1_d = '0;
        rd2_d = '0;
        for (int k = 0; k < int'(RD0_WORDS); k++) rd0_d[WORD_W*k +: WORD_W] = rd_word[0][k];
        for (int k = 0; k < int'(RD1_WORDS); k++) rd1_d[WORD_W*k +: WORD_W] = rd_word[1][k];
        for (int k = 0; k < int'(RD2_WORDS); k++) rd2_d[WORD_W*k +: WORD_W] = rd_word[2][k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_q      <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            rd_valid_q <= '0;
            wr_err_q   <= '0;
        end else begin
            rd_valid_q <= {bus.rd2_en, bus.rd1_en, bus.rd0_en};
            if (bus.rd0_en) rd0_q <= rd0_d;
            if (bus.rd1_en) rd1_q <= rd1_d;
            if (bus.rd2_en) rd2_q <= rd2_d;
            wr_err_q   <= wr_err_q | ~wr_legal;
        end
    end

    assign bus.rd0_data  = rd0_q;
    assign bus.rd1_data  = rd1_q;
    assign bus.rd2_data  = rd2_q;
    assign bus.rd0_valid = rd_valid_q[0];
    assign bus.rd1_valid = rd_valid_q[1];
    assign bus.rd2_valid = rd_valid_q[2];
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_sgpr_banked_rf.sv
// tb_sgpr_banked_rf: directed scoreboard bench for sgpr_banked_rf.
// Read expectations are queued per port when a read is issued and checked
// one cycle later; idle ports must show valid=0 with data held.
module tb_sgpr_banked_rf;

    logic clk;
    logic rst;

    sgpr_banked_rf_if bus ();

    sgpr_banked_rf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    string step = "";

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] q2[$];
    logic [127:0] last [3];
    logic [2:0]   issued;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h expected %h", step, tag, obs, exp);
        end
    endtask

    task automatic chk_err(input logic [2:0] exp);
        chk("wr_err", 128'(bus.wr_err), 128'(exp));
    endtask

    task automatic clear_inputs();
        bus.rd0_en = 1'b0; bus.rd0_addr = '0;
        bus.rd1_en = 1'b0; bus.rd1_addr = '0;
        bus.rd2_en = 1'b0; bus.rd2_addr = '0;
        bus.wr0_en = '0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = '0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.wr2_en = '0; bus.wr2_addr = '0; bus.wr2_data = '0;
    endtask

    task automatic wr(input int p, input logic [3:0] mask, input logic [8:0] addr,
                      input logic [127:0] data);
        case (p)
            0: begin bus.wr0_en = mask;      bus.wr0_addr = addr; bus.wr0_data = data;        end
            1: begin bus.wr1_en = mask[1:0]; bus.wr1_addr = addr; bus.wr1_data = data[63:0];  end
            default: begin bus.wr2_en = mask[1:0]; bus.wr2_addr = addr; bus.wr2_data = data[63:0]; end
        endcase
    endtask

    task automatic rd(input int p, input logic [8:0] addr, input logic [127:0] exp);
        case (p)
            0: begin bus.rd0_en = 1'b1; bus.rd0_addr = addr; q0.push_back(exp); end
            1: begin bus.rd1_en = 1'b1; bus.rd1_addr = addr; q1.push_back(exp); end
            default: begin bus.rd2_en = 1'b1; bus.rd2_addr = addr; q2.push_back(exp); end
        endcase
        issued[p] = 1'b1;
    endtask

    task automatic check_port(input int p, input logic v, input logic [127:0] d);
        logic [127:0] e;
        e = last[p];
        if (issued[p]) begin
            case (p)
                0: if (q0.size() > 0) e = q0.pop_front();
                1: if (q1.size() > 0) e = q1.pop_front();
                default: if (q2.size() > 0) e = q2.pop_front();
            endcase
            chk($sformatf("rd%0d_valid", p), 128'(v), 128'(1'b1));
            chk($sformatf("rd%0d_data", p), d, e);
            last[p] = e;
        end else begin
            chk($sformatf("rd%0d_valid", p), 128'(v), 128'(1'b0));
            chk($sformatf("rd%0d_hold", p), d, last[p]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_port(0, bus.rd0_valid, 128'(bus.rd0_data));
        check_port(1, bus.rd1_valid, 128'(bus.rd1_data));
        check_port(2, bus.rd2_valid, 128'(bus.rd2_data));
        clear_inputs();
        issued = '0;
    endtask

    localparam logic [127:0] ALIGNED = {32'hDDDD_0011, 32'hCCCC_0010, 32'hBBBB_0009, 32'hAAAA_0008};

    initial begin
        rst = 1'b1;
        issued = '0;
        for (int i = 0; i < 3; i++) last[i] = '0;
        clear_inputs();

        step = "reset";
        repeat (2) @(posedge clk);
        #1;
        chk("rd0_valid", 128'(bus.rd0_valid), 128'(1'b0));
        chk("rd0_data",  128'(bus.rd0_data),  128'(0));
        chk("rd1_valid", 128'(bus.rd1_valid), 128'(1'b0));
        chk("rd1_data",  128'(bus.rd1_data),  128'(0));
        chk("rd2_valid", 128'(bus.rd2_valid), 128'(1'b0));
        chk("rd2_data",  128'(bus.rd2_data),  128'(0));
        chk_err(3'b000);
        rst = 1'b0;

        step = "aligned";
        wr(0, 4'hF, 9'd8, ALIGNED);
        cycle();
        rd(0, 9'd8, ALIGNED);
        cycle();

        step = "wrap";
        wr(0, 4'hF, 9'd508, {32'h1FF, 32'h1FE, 32'h1FD, 32'h1FC});
        wr(1, 4'h3, 9'd0,   128'({32'h001, 32'h000}));
        cycle();
        rd(0, 9'd509, {32'h000, 32'h1FF, 32'h1FE, 32'h1FD});
        rd(1, 9'd511, 128'({32'h000, 32'h1FF}));
        rd(2, 9'd508, 128'({32'h1FD, 32'h1FC}));
        cycle();

        step = "collision";
        wr(0, 4'h1, 9'd20, 128'(32'hAAAA));
        wr(1, 4'h1, 9'd20, 128'(32'hBBBB));
        wr(2, 4'h3, 9'd20, 128'({32'hC21, 32'hC20}));
        cycle();
        wr(1, 4'h1, 9'd24, 128'(32'h1111));
        wr(2, 4'h3, 9'd24, 128'({32'h2225, 32'h2224}));
        rd(1, 9'd20, 128'({32'hC21, 32'hAAAA}));
        cycle();
        rd(2, 9'd24, 128'({32'h2225, 32'h1111}));
        cycle();
        chk_err(3'b000);

        step = "illegal";
        wr(2, 4'h1, 9'd3, 128'(32'h303));
        wr(0, 4'hF, 9'd4, {32'h707, 32'h606, 32'h505, 32'h404});
        cycle();
        wr(1, 4'h3, 9'd3, 128'({32'hBAD4, 32'hBAD3}));
        cycle();
        chk_err(3'b010);
        rd(0, 9'd3, {32'h606, 32'h505, 32'h404, 32'h303});
        cycle();
        chk_err(3'b010);
        wr(1, 4'h2, 9'd6, 128'({32'hBAD7, 32'hBAD6}));
        wr(0, 4'h0, 9'd3, 128'(32'hEEEE));
        cycle();
        chk_err(3'b010);
        rd(1, 9'd6, 128'({32'h707, 32'h606}));
        rd(0, 9'd3, {32'h606, 32'h505, 32'h404, 32'h303});
        cycle();
        wr(2, 4'h3, 9'd5, 128'({32'hBAD6, 32'hBAD5}));
        cycle();
        chk_err(3'b110);
        rd(2, 9'd5, 128'({32'h606, 32'h505}));
        cycle();

        step = "rdw";
        wr(2, 4'h3, 9'd40, 128'({32'h41, 32'h1}));
        cycle();
        wr(2, 4'h1, 9'd40, 128'(32'h2));
`ifdef SGPR_RF_BYPASS_EN
        rd(2, 9'd40, 128'({32'h41, 32'h2}));
`else
        rd(2, 9'd40, 128'({32'h41, 32'h1}));
`endif
        cycle();
        rd(2, 9'd40, 128'({32'h41, 32'h2}));
        cycle();
        wr(0, 4'h1, 9'd41, 128'(32'hA41));
        wr(2, 4'h3, 9'd40, 128'({32'hC41, 32'hC40}));
`ifdef SGPR_RF_BYPASS_EN
        rd(1, 9'd40, 128'({32'hA41, 32'hC40}));
`else
        rd(1, 9'd40, 128'({32'h41, 32'h2}));
`endif
        cycle();
        rd(2, 9'd40, 128'({32'hA41, 32'hC40}));
        cycle();

        step = "idle";
        cycle();
        rd(0, 9'd8, ALIGNED);
        cycle();

        step = "reset_mid";
        bus.rd0_en = 1'b1;
        bus.rd0_addr = 9'd8;
        wr(0, 4'hF, 9'd8, {4{32'hEEEE_EEEE}});
        rst = 1'b1;
        #1;
        chk("rd0_valid", 128'(bus.rd0_valid), 128'(1'b0));
        chk("rd0_data",  128'(bus.rd0_data),  128'(0));
        chk_err(3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.wr0_en = '0;
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) last[i] = '0;
        chk("rd0_valid_post", 128'(bus.rd0_valid), 128'(1'b0));
        rd(0, 9'd8, ALIGNED);
        cycle();
        chk_err(3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
